// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared definitions for the iterative HI/LO divider.
//   - FSM state encodings (DivFree, DivByZero, DivOn, DivEnd)
//   - result-ready and start/stop level names
//   - RegBus: default datapath width
package div_unit_pkg;

    localparam int RegBus = 32;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_unit_if.sv
// div_if: request/response bundle between EX and the divider.
//   master (EX side): drives signed_div_i, opdata1_i, opdata2_i, start_i,
//                     annul_i; receives result_o, ready_o, busy_o.
//   slave  (divider): the mirror image.
interface div_if #(
    parameter int DATA_W = 32
);
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
    logic                  busy_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, busy_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, busy_o
    );
endinterface

// File: rtl/div_unit_step.sv
// div_step: one combinational restoring-division iteration.
//   rem_in  : current partial remainder (always < divisor)
//   bit_in  : next dividend bit shifted in
//   divisor : magnitude of the divisor
//   rem_out : updated partial remainder
//   q_bit   : quotient bit produced by this iteration
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem_in,
    input  logic              bit_in,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_out,
    output logic              q_bit
);
    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;

    // rem_in < divisor, so the shifted value fits in DATA_W+1 bits and a
    // borrow out of the trial subtract shows up in the top bit.
    assign shifted = {rem_in, bit_in};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = ~diff[DATA_W];
    assign rem_out = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle signed/unsigned integer divider, one quotient bit
// per clock, result {remainder, quotient}.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : div_if.slave (operands, start/annul, result/ready/busy)
// Optional build macro DIV_EARLY_OUT_EN: when |dividend| < |divisor| the
// answer {dividend, 0} is produced straight from FREE in one cycle.
module div_unit
    import div_unit_pkg::*;
#(
    parameter  int DATA_W = RegBus,
    localparam int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);
    div_state_e              state_q, state_d;
    logic [DATA_W-1:0]       dvd_q;      // dividend bits out, quotient bits in
    logic [DATA_W-1:0]       dvs_q;
    logic [DATA_W-1:0]       rem_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    q_neg_q, r_neg_q;
    logic [2*DATA_W-1:0]     result_q;
    logic                    ready_q;
    logic                    busy;

    logic                    op1_neg, op2_neg;
    logic [DATA_W-1:0]       abs1, abs2;
    logic                    accept, div_zero, early, step_done;
    logic [DATA_W-1:0]       step_rem, q_raw, q_fix, r_fix;
    logic                    step_q;

    assign op1_neg  = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
    assign op2_neg  = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
    assign abs1     = op1_neg ? -bus.opdata1_i : bus.opdata1_i;
    assign abs2     = op2_neg ? -bus.opdata2_i : bus.opdata2_i;
    assign accept   = (bus.start_i == DivStart) && !bus.annul_i;
    assign div_zero = (bus.opdata2_i == '0);

`ifdef DIV_EARLY_OUT_EN
    assign early = (abs1 < abs2);
`else
    assign early = 1'b0;
`endif

    div_step #(.DATA_W(DATA_W)) u_step (
        .rem_in  (rem_q),
        .bit_in  (dvd_q[DATA_W-1]),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    assign step_done = (cnt_q == CNT_W'(DATA_W - 1));
    assign q_raw     = {dvd_q[DATA_W-2:0], step_q};
    assign q_fix     = q_neg_q ? -q_raw : q_raw;
    assign r_fix     = r_neg_q ? -step_rem : step_rem;

    // Next-state and busy.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        case (state_q)
            DivFree: begin
                if (accept) begin
                    if (div_zero)   state_d = DivByZero;
                    else if (early) state_d = DivEnd;
                    else            state_d = DivOn;
                end
            end
            DivByZero: begin
                busy    = 1'b1;
                state_d = bus.annul_i ? DivFree : DivEnd;
            end
            DivOn: begin
                busy = 1'b1;
                if (bus.annul_i)    state_d = DivFree;
                else if (step_done) state_d = DivEnd;
            end
            DivEnd: begin
                if (bus.start_i == DivStop) state_d = DivFree;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= DivFree;
        else      state_q <= state_d;
    end

    // Datapath registers follow the same transitions as the FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
            ready_q  <= DivResultNotReady;
        end else begin
            case (state_q)
                DivFree: begin
                    if (accept) begin
                        dvd_q   <= abs1;
                        dvs_q   <= abs2;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        q_neg_q <= op1_neg ^ op2_neg;
                        r_neg_q <= op1_neg;
                        if (!div_zero && early) begin
                            // Quotient is zero; remainder is the dividend as given.
                            result_q <= {bus.opdata1_i, {DATA_W{1'b0}}};
                            ready_q  <= DivResultReady;
                        end
                    end
                end
                DivByZero: begin
                    if (!bus.annul_i) begin
                        result_q <= '0;
                        ready_q  <= DivResultReady;
                    end
                end
                DivOn: begin
                    if (!bus.annul_i) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        dvd_q <= q_raw;
                        rem_q <= step_rem;
                        if (step_done) begin
                            result_q <= {r_fix, q_fix};
                            ready_q  <= DivResultReady;
                        end
                    end
                end
                DivEnd: begin
                    if (bus.start_i == DivStop) begin
                        result_q <= '0;
                        ready_q  <= DivResultNotReady;
                    end
                end
            endcase
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;
    assign bus.busy_o   = busy;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: self-checking bench for div_unit (DATA_W = 32). Expected
// results come from 64-bit integer division; expected latency from the
// operand classes (zero divisor, early-out, full iteration).
module tb_div_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    div_if #(.DATA_W(W)) bus ();

    div_unit #(.DATA_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int ref_lat(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (b == 32'd0) return 2;
        sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        if (sa < 0) sa = -sa;
        if (sb < 0) sb = -sb;
`ifdef DIV_EARLY_OUT_EN
        if (sa < sb) return 1;
`endif
        return W + 1;
    endfunction

    // Issue one division at #1 after a rising edge, check latency, busy
    // profile, result, hold stability and release back to FREE.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input int hold);
        int          lat, n;
        logic        busy_ok;
        logic [63:0] exp;
        exp = ref_div(sgn, a, b);
        lat = ref_lat(sgn, a, b);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.annul_i      = 1'b0;
        bus.start_i      = 1'b1;
        n       = 0;
        busy_ok = 1'b1;
        while (bus.ready_o !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (bus.busy_o !== (n < lat)) busy_ok = 1'b0;
            // Operands are latched at acceptance; wiggle them afterwards.
            bus.opdata1_i    = $urandom;
            bus.opdata2_i    = $urandom;
            bus.signed_div_i = 1'($urandom_range(0, 1));
        end
        check({tag, ".lat"},    72'(n), 72'(lat));
        check({tag, ".result"}, 72'(bus.result_o), 72'(exp));
        check({tag, ".busy"},   72'(busy_ok), 72'd1);
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk); #1;
            end
            check({tag, ".hold"}, 72'({bus.ready_o, bus.busy_o, bus.result_o}), 72'({2'b10, exp}));
        end
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        check({tag, ".clear"}, 72'({bus.ready_o, bus.busy_o, bus.result_o}), 72'd0);
    endtask

    initial begin
        int   n;
        logic rdy_seen;
        logic [31:0] a, b;

        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset", 72'({bus.ready_o, bus.busy_o, bus.result_o}), 72'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        run_div("u100_7",  1'b0, 32'd100,        32'd7,          0);
        check("u100_7.const", 72'(ref_div(1'b0, 32'd100, 32'd7)), 72'h00000002_0000000E);
        run_div("s-7_2",   1'b1, 32'hFFFF_FFF9,  32'd2,          1);
        run_div("s7_-2",   1'b1, 32'd7,          32'hFFFF_FFFE,  0);
        run_div("div0",    1'b0, 32'd5,          32'd0,          5);
        run_div("u3_10",   1'b0, 32'd3,          32'd10,         0);
        run_div("s-3_10",  1'b1, 32'hFFFF_FFFD,  32'd10,         0);
        run_div("umax_1",  1'b0, 32'hFFFF_FFFF,  32'd1,          0);

        // Annul mid-ON: back to FREE next edge, no ready pulse.
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd1000;
        bus.opdata2_i    = 32'd3;
        bus.start_i      = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("annul.busy_before", 72'(bus.busy_o), 72'd1);
        bus.annul_i = 1'b1;
        @(posedge clk); #1;
        check("annul.free", 72'({bus.ready_o, bus.busy_o, bus.result_o}), 72'd0);
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        rdy_seen = 1'b0;
        repeat (36) begin
            @(posedge clk); #1;
            if (bus.ready_o !== 1'b0 || bus.busy_o !== 1'b0) rdy_seen = 1'b1;
        end
        check("annul.no_ready", 72'(rdy_seen), 72'd0);

        // Annul in FREE blocks acceptance, even with start held.
        bus.opdata1_i = 32'd9;
        bus.opdata2_i = 32'd3;
        bus.start_i   = 1'b1;
        bus.annul_i   = 1'b1;
        rdy_seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.ready_o !== 1'b0 || bus.busy_o !== 1'b0) rdy_seen = 1'b1;
        end
        check("annul.blocks", 72'(rdy_seen), 72'd0);
        run_div("u9_3", 1'b0, 32'd9, 32'd3, 0);

        // Asynchronous reset in the middle of an iteration.
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'h1234_5678;
        bus.opdata2_i    = 32'd17;
        bus.start_i      = 1'b1;
        repeat (15) begin
            @(posedge clk); #1;
        end
        check("areset.busy_before", 72'(bus.busy_o), 72'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("areset.outputs", 72'({bus.ready_o, bus.busy_o, bus.result_o}), 72'd0);
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_div("s_min_-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("s_min_-1.const", 72'(ref_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF)), 72'h00000000_80000000);

        // Randomized operations against the reference model.
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = $urandom;
                default: b = -32'($urandom_range(1, 15));
            endcase
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 20));
            run_div("rand", 1'($urandom_range(0, 1)), a, b, $urandom_range(0, 2));
        end

        n = n_total;
        $display("%0d/%0d checks passed", n_pass, n);
        $finish;
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Parametrised multi-cycle integer divider for the HI/LO datapath.
- Executes signed and unsigned DIV/DIVU from the EX stage, one quotient bit per cycle.
- Returns {remainder, quotient}, written to HI/LO through the existing whilo path.
- Generalises the single-cycle HI/LO arithmetic to a DATA_W-wide iterative unit with start/ready handshake, annul, and divide-by-zero handling.

Parameters:
- DATA_W, 32, operand width in bits; must be ≥ 4.
- CNT_W, $clog2(DATA_W)+1, iteration counter width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at start.
- opdata1_i  in  DATA_W  dividend; sampled at start.
- opdata2_i  in  DATA_W  divisor; sampled at start.
- start_i  in  1  request; held high by EX until ready_o is seen.
- annul_i  in  1  cancel in-flight division (pipeline flush).
- result_o  out  2*DATA_W  {remainder[2W-1:W], quotient[W-1:0]}.
- ready_o  out  1  result_o valid.
- busy_o  out  1  unit occupied; drives the pipeline stall request.

Behaviour:
- Reset (rst low, asynchronous):
  - state = FREE; result_o = 0; ready_o = 0; busy_o = 0; counter = 0; internal dividend/divisor registers = 0.
- States: FREE, BYZERO, ON, END (shared 2-bit encoding).
- FREE:
  - start_i=1, annul_i=0, opdata2_i=0 → BYZERO.
  - start_i=1, annul_i=0, opdata2_i≠0 → ON.
  - On entry to ON: latch |op1| and |op2|. Absolute values are taken only when signed_div_i=1 and the operand MSB=1 (two's-complement negate).
  - Latch sign flags: quotient negative = sign1 XOR sign2; remainder negative = sign1.
  - counter = 0. busy_o = 1 from the cycle after acceptance.
- BYZERO: one cycle → END with result_o = 0.
- ON: restoring step per cycle on a (DATA_W+1)-bit partial remainder.
  - Shift left by 1 and bring in the next dividend bit.
  - Trial subtract the divisor; if the result is non-negative, keep it and the quotient bit = 1, else restore and the quotient bit = 0.
  - counter increments each step.
  - After DATA_W steps → END. Apply sign correction (negate quotient and/or remainder per the latched flags) on the final transition.
  - Total latency, start accepted → ready_o high = DATA_W + 1 cycles.
- END:
  - ready_o = 1; result_o holds the final value; busy_o = 0.
  - Stays in END while start_i = 1.
  - start_i = 0 → FREE with ready_o = 0 and result_o = 0 on the same edge.
  - A new start is accepted only from FREE, so back-to-back divisions need one idle cycle.
- annul_i:
  - In ON or BYZERO: → FREE next edge; no ready_o pulse; result discarded.
  - In FREE: blocks acceptance.
  - In END: ignored.
- Simultaneous start_i and annul_i in FREE: annul wins.
- Signed corner cases:
  - Most-negative / -1 (0x80000000 / 0xFFFFFFFF at W=32): quotient 0x80000000, remainder 0 (wrap, no trap).
  - Remainder sign always follows the dividend.
- Operands are not re-sampled after acceptance; input changes during ON have no effect.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in FREE, if |op1| < |op2| (unsigned compare of absolute values, divisor ≠ 0), skip ON and go directly → END.
  - Quotient = 0; remainder = op1 unchanged, including its sign.
  - Latency is 1 cycle. busy_o never asserts.
- Undefined: every non-zero-divisor operation takes the full DATA_W + 1 cycles.
- Results are bit-identical with and without the macro.

Decomposition:
- Shared defines package:
  - state encodings DivFree, DivByZero, DivOn, DivEnd;
  - DivResultReady / DivResultNotReady;
  - DivStart / DivStop;
  - DATA_W default tied to RegBus width.
- Natural sub-module: div_step, a combinational one-iteration shift/trial-subtract. It is reused if a radix-4 variant is later built.

Test Plan:
- Unsigned, W=32: 100 / 7 → ready_o after 33 cycles; result_o = {0x00000002, 0x0000000E}; busy_o high for cycles 1–32.
- Signed: -7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also 7 / -2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero: 5 / 0 → BYZERO, then END; ready_o at cycle 2; result_o = 0. Hold start_i for 5 more cycles → result stable; drop start_i → FREE.
- Annul: start 1000 / 3, assert annul_i at cycle 10 → FREE next edge; ready_o never rises. A new 9 / 3 then completes with quotient 3, remainder 0.
- Async reset mid-ON (cycle 15, rst low between clock edges) → all outputs 0 immediately. After release, 0x80000000 / 0xFFFFFFFF signed → quotient 0x80000000, remainder 0.
- DIV_EARLY_OUT_EN defined: 3 / 10 → ready_o at cycle 1, result {3, 0}. Undefined: same operands → cycle 33, same result.
